cl_axi_mem_responder: RTL and testbench

AXI4 slave endpoint that terminates the registered dma_pcis path (the master side of the CL register slice) and serves it from a local on-chip buffer. Host DMA writes PairHMM input batches into the buffer and reads back results, using INCR bursts. Independent write and read channels share one simple-dual-port RAM: one write port and one read port.

---
 rtl/cl_axi_mem_pkg.sv | 26 ++
 rtl/axi_if.sv | 52 +++++
 rtl/cl_sdp_ram.sv | 35 +++
 rtl/cl_axi_mem_responder.sv | 197 +++++++++++++++++++
 tb/tb_cl_axi_mem_responder.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/cl_axi_mem_pkg.sv
// Shared types and helpers for the dma_pcis buffer responder.
//   wr_state_t / rd_state_t : write and read channel FSM states
//   RESP_OKAY / RESP_SLVERR : AXI response codes used by this slave
//   addr_lsb()              : byte-offset width of one data word
package cl_axi_mem_pkg;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } wr_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Number of address bits that select a byte inside one data word.
  function automatic int addr_lsb(input int data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/axi_if.sv
// AXI4 bundle carrying only the signals the buffer responder uses.
//   modport slave  : responder side (drives ready/response signals)
//   modport master : host / register-slice side
interface axi_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 512,
  parameter int ID_W   = 6
) ();
  logic [ID_W-1:0]     awid;
  logic [ADDR_W-1:0]   awaddr;
  logic [7:0]          awlen;
  logic [2:0]          awsize;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;
  logic [ID_W-1:0]     bid;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ID_W-1:0]     arid;
  logic [ADDR_W-1:0]   araddr;
  logic [7:0]          arlen;
  logic [2:0]          arsize;
  logic                arvalid;
  logic                arready;
  logic [ID_W-1:0]     rid;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rlast;
  logic                rvalid;
  logic                rready;

  modport slave (
    input  awid, awaddr, awlen, awsize, awvalid, output awready,
    input  wdata, wstrb, wlast, wvalid, output wready,
    output bid, bresp, bvalid, input bready,
    input  arid, araddr, arlen, arsize, arvalid, output arready,
    output rid, rdata, rresp, rlast, rvalid, input rready
  );

  modport master (
    output awid, awaddr, awlen, awsize, awvalid, input awready,
    output wdata, wstrb, wlast, wvalid, input wready,
    input  bid, bresp, bvalid, output bready,
    output arid, araddr, arlen, arsize, arvalid, input arready,
    input  rid, rdata, rresp, rlast, rvalid, output rready
  );
endinterface

// File: rtl/cl_sdp_ram.sv
// Simple-dual-port buffer RAM: one byte-enabled write port, one read port
// with a registered output (latency 1). A read and a write to the same
// word in the same cycle return the old contents (read-first).
//   clk_i                         : clock
//   we_i, waddr_i, wdata_i, wbe_i : write port, wbe_i one bit per byte lane
//   re_i, raddr_i, rdata_o        : read port, rdata_o updates only when re_i
module cl_sdp_ram #(
  parameter int DATA_W = 512,
  parameter int DEPTH  = 1024
) (
  input  logic                       clk_i,
  input  logic                       we_i,
  input  logic [$clog2(DEPTH)-1:0]   waddr_i,
  input  logic [DATA_W-1:0]          wdata_i,
  input  logic [DATA_W/8-1:0]        wbe_i,
  input  logic                       re_i,
  input  logic [$clog2(DEPTH)-1:0]   raddr_i,
  output logic [DATA_W-1:0]          rdata_o
);
  localparam int BE_W = DATA_W / 8;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (re_i) rdata_q <= mem_q[raddr_i];
    if (we_i) begin
      for (int b = 0; b < BE_W; b++) begin
        if (wbe_i[b]) mem_q[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
      end
    end
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/cl_axi_mem_responder.sv
// AXI4 slave endpoint on the dma_pcis path, backed by a local buffer.
// Independent write (AW/W/B) and read (AR/R) FSMs share one SDP RAM.
// INCR bursts only, full-width beats, one burst outstanding per channel.
//   aclk    : clock
//   aresetn : asynchronous active-low reset
//   s_axi   : AXI4 slave port (axi_if.slave)
module cl_axi_mem_responder
  import cl_axi_mem_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 512,
  parameter int ID_W   = 6,
  parameter int DEPTH  = 1024
) (
  input logic  aclk,
  input logic  aresetn,
  axi_if.slave s_axi
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int LSB   = addr_lsb(DATA_W);

  // ---------------- write channel ----------------
  wr_state_t         wr_state_q, wr_state_d;
  logic [ID_W-1:0]   wid_q, wid_d;
  logic [IDX_W-1:0]  widx_q, widx_d;
  logic [7:0]        wcnt_q, wcnt_d;
  logic              werr_q, werr_d;
  logic [1:0]        bresp_q, bresp_d;
  logic              awready_q, wready_q, bvalid_q;
  logic              ram_we;
  logic              wlast_bad;

  always_comb begin
    wr_state_d = wr_state_q;
    wid_d      = wid_q;
    widx_d     = widx_q;
    wcnt_d     = wcnt_q;
    werr_d     = werr_q;
    bresp_d    = bresp_q;
    ram_we     = 1'b0;
    // wlast only flags an error; the burst length always comes from len.
    wlast_bad  = (s_axi.wlast != (wcnt_q == 8'd0));
    case (wr_state_q)
      W_IDLE: begin
        if (s_axi.awvalid && awready_q) begin
          wid_d      = s_axi.awid;
          widx_d     = s_axi.awaddr[LSB +: IDX_W];
          wcnt_d     = s_axi.awlen;
          werr_d     = 1'b0;
          wr_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (s_axi.wvalid && wready_q) begin
          ram_we = 1'b1;
          widx_d = widx_q + 1'b1;
          wcnt_d = wcnt_q - 8'd1;
          if (wlast_bad) werr_d = 1'b1;
          if (wcnt_q == 8'd0) begin
            bresp_d    = (werr_q || wlast_bad) ? RESP_SLVERR : RESP_OKAY;
            wr_state_d = W_RESP;
          end
        end
      end
      W_RESP: begin
        if (s_axi.bready && bvalid_q) wr_state_d = W_IDLE;
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_state_q <= W_IDLE;
      wid_q      <= '0;
      widx_q     <= '0;
      wcnt_q     <= '0;
      werr_q     <= 1'b0;
      bresp_q    <= RESP_OKAY;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
    end else begin
      wr_state_q <= wr_state_d;
      wid_q      <= wid_d;
      widx_q     <= widx_d;
      wcnt_q     <= wcnt_d;
      werr_q     <= werr_d;
      bresp_q    <= bresp_d;
      // Ready/valid are registered from the next state so they are low in reset.
      awready_q  <= (wr_state_d == W_IDLE);
      wready_q   <= (wr_state_d == W_DATA);
      bvalid_q   <= (wr_state_d == W_RESP);
    end
  end

  // ---------------- read channel ----------------
  rd_state_t         rd_state_q, rd_state_d;
  logic [ID_W-1:0]   rid_q, rid_d;
  logic [IDX_W-1:0]  ridx_q, ridx_d;
  logic [8:0]        rrem_q, rrem_d;   // beats still to issue to the RAM
  logic              rvalid_q, rvalid_d;
  logic              rlast_q, rlast_d;
  logic              arready_q;
  logic              ram_re;
  logic [DATA_W-1:0] ram_rdata;

  // Issue a RAM read whenever the output slot is free or being drained.
  assign ram_re = (rd_state_q == R_DATA) && (rrem_q != 9'd0) &&
                  (!rvalid_q || s_axi.rready);

  always_comb begin
    rd_state_d = rd_state_q;
    rid_d      = rid_q;
    ridx_d     = ridx_q;
    rrem_d     = rrem_q;
    rvalid_d   = rvalid_q;
    rlast_d    = rlast_q;
    case (rd_state_q)
      R_IDLE: begin
        if (s_axi.arvalid && arready_q) begin
          rid_d      = s_axi.arid;
          ridx_d     = s_axi.araddr[LSB +: IDX_W];
          rrem_d     = {1'b0, s_axi.arlen} + 9'd1;
          rd_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (rvalid_q && s_axi.rready && rlast_q) rd_state_d = R_IDLE;
      end
      default: rd_state_d = R_IDLE;
    endcase
    if (ram_re) begin
      ridx_d   = ridx_q + 1'b1;
      rrem_d   = rrem_q - 9'd1;
      rvalid_d = 1'b1;
      rlast_d  = (rrem_q == 9'd1);
    end else if (s_axi.rready) begin
      rvalid_d = 1'b0;
      rlast_d  = 1'b0;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rd_state_q <= R_IDLE;
      rid_q      <= '0;
      ridx_q     <= '0;
      rrem_q     <= '0;
      rvalid_q   <= 1'b0;
      rlast_q    <= 1'b0;
      arready_q  <= 1'b0;
    end else begin
      rd_state_q <= rd_state_d;
      rid_q      <= rid_d;
      ridx_q     <= ridx_d;
      rrem_q     <= rrem_d;
      rvalid_q   <= rvalid_d;
      rlast_q    <= rlast_d;
      arready_q  <= (rd_state_d == R_IDLE);
    end
  end

  cl_sdp_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk_i   (aclk),
    .we_i    (ram_we),
    .waddr_i (widx_q),
    .wdata_i (s_axi.wdata),
    .wbe_i   (s_axi.wstrb),
    .re_i    (ram_re),
    .raddr_i (ridx_q),
    .rdata_o (ram_rdata)
  );

  // ---------------- outputs ----------------
  assign s_axi.awready = awready_q;
  assign s_axi.wready  = wready_q;
  assign s_axi.bvalid  = bvalid_q;
  assign s_axi.bid     = wid_q;
  assign s_axi.bresp   = bresp_q;
  assign s_axi.arready = arready_q;
  assign s_axi.rvalid  = rvalid_q;
  assign s_axi.rlast   = rlast_q;
  assign s_axi.rid     = rid_q;
  assign s_axi.rresp   = RESP_OKAY;
  // The RAM output register is not reset; masking keeps rdata at zero
  // whenever no beat is presented, including during and after reset.
  assign s_axi.rdata   = rvalid_q ? ram_rdata : '0;

  // Size fields and upper address bits are intentionally ignored.
  logic unused_ok;
  assign unused_ok = ^{s_axi.awsize, s_axi.arsize, s_axi.awaddr, s_axi.araddr};

endmodule

// File: tb/tb_cl_axi_mem_responder.sv
module tb_cl_axi_mem_responder;
  localparam int DW    = 512;
  localparam int DEPTH = 1024;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axi_if #(.ADDR_W(64), .DATA_W(DW), .ID_W(6)) bus ();

  cl_axi_mem_responder #(
    .ADDR_W (64),
    .DATA_W (DW),
    .ID_W   (6),
    .DEPTH  (DEPTH)
  ) dut (
    .aclk    (clk),
    .aresetn (rst_n),
    .s_axi   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [DW-1:0] model [DEPTH];
  logic [DW-1:0] wbuf  [16];

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] pat(input int i);
    logic [31:0] w;
    w = 32'hC0DE_0000 + 32'(i);
    return {16{w}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Write burst: AW, len+1 W beats from wbuf, then B check.
  // bad_last >= 0 places wlast on that beat instead of the final one.
  task automatic wr_burst(input logic [5:0] id, input logic [63:0] addr, input int len,
                          input logic [63:0] strb, input int bad_last, input logic [1:0] exp_resp);
    int t;
    int idx;
    idx = int'(addr[15:6]);
    bus.awid = id; bus.awaddr = addr; bus.awlen = 8'(len); bus.awsize = 3'd6; bus.awvalid = 1'b1;
    t = 0;
    while (!bus.awready && t < 100) begin tick(); t++; end
    if (t >= 100) check("aw_timeout", 0, 1);
    tick();
    bus.awvalid = 1'b0;
    for (int i = 0; i <= len; i++) begin
      bus.wvalid = 1'b1; bus.wdata = wbuf[i]; bus.wstrb = strb;
      bus.wlast = (bad_last >= 0) ? (i == bad_last) : (i == len);
      t = 0;
      while (!bus.wready && t < 100) begin tick(); t++; end
      if (t >= 100) check("w_timeout", 0, 1);
      tick();
      for (int b = 0; b < DW/8; b++)
        if (strb[b]) model[(idx + i) % DEPTH][b*8 +: 8] = wbuf[i][b*8 +: 8];
    end
    bus.wvalid = 1'b0; bus.wlast = 1'b0;
    bus.bready = 1'b1;
    t = 0;
    while (!bus.bvalid && t < 100) begin tick(); t++; end
    if (t >= 100) check("b_timeout", 0, 1);
    check("bresp", DW'(bus.bresp), DW'(exp_resp));
    check("bid", DW'(bus.bid), DW'(id));
    $display("B   id=%0d idx=%0d len=%0d resp=%0d", bus.bid, idx, len, bus.bresp);
    tick();
    bus.bready = 1'b0;
  endtask

  task automatic ar_send(input logic [5:0] id, input logic [63:0] addr, input int len);
    int t;
    bus.arid = id; bus.araddr = addr; bus.arlen = 8'(len); bus.arsize = 3'd6; bus.arvalid = 1'b1;
    t = 0;
    while (!bus.arready && t < 100) begin tick(); t++; end
    if (t >= 100) check("ar_timeout", 0, 1);
    tick();
    bus.arvalid = 1'b0;
  endtask

  // Collect n beats, checking data against the model, rlast, rid, and
  // stability of a stalled beat. toggle alternates rready 1/0.
  task automatic r_collect(input logic [5:0] id, input int idx, input int n, input bit toggle);
    int got, t;
    bit stalled;
    logic [DW-1:0] held;
    got = 0; t = 0; stalled = 1'b0; held = '0;
    while (got < n && t < 600) begin
      bus.rready = toggle ? ((t % 2) == 0) : 1'b1;
      if (stalled) begin
        check("r_hold_valid", DW'(bus.rvalid), DW'(1));
        check("r_hold_data", bus.rdata, held);
      end
      stalled = 1'b0;
      if (bus.rvalid) begin
        if (bus.rready) begin
          check("rdata", bus.rdata, model[(idx + got) % DEPTH]);
          check("rlast", DW'(bus.rlast), DW'(got == n - 1));
          check("rid", DW'(bus.rid), DW'(id));
          check("rresp", DW'(bus.rresp), DW'(0));
          got++;
        end else begin
          held = bus.rdata;
          stalled = 1'b1;
        end
      end
      tick();
      t++;
    end
    bus.rready = 1'b0;
    check("r_beats", DW'(got), DW'(n));
    $display("R   id=%0d idx=%0d beats=%0d", id, idx, got);
  endtask

  initial begin
    int lat, got;
    logic [DW-1:0] a_pat, exp_v;

    bus.awvalid = 0; bus.awid = 0; bus.awaddr = 0; bus.awlen = 0; bus.awsize = 0;
    bus.wvalid = 0; bus.wdata = 0; bus.wstrb = 0; bus.wlast = 0; bus.bready = 0;
    bus.arvalid = 0; bus.arid = 0; bus.araddr = 0; bus.arlen = 0; bus.arsize = 0;
    bus.rready = 0;

    // Reset values
    repeat (3) tick();
    check("rst_awready", DW'(bus.awready), DW'(0));
    check("rst_wready", DW'(bus.wready), DW'(0));
    check("rst_bvalid", DW'(bus.bvalid), DW'(0));
    check("rst_bid_bresp", DW'({bus.bid, bus.bresp}), DW'(0));
    check("rst_arready", DW'(bus.arready), DW'(0));
    check("rst_rvalid_rlast", DW'({bus.rvalid, bus.rlast}), DW'(0));
    check("rst_rid_rresp", DW'({bus.rid, bus.rresp}), DW'(0));
    check("rst_rdata", bus.rdata, '0);
    rst_n = 1'b1;
    tick(); tick();
    check("idle_awready", DW'(bus.awready), DW'(1));
    check("idle_arready", DW'(bus.arready), DW'(1));

    // Single beat write + read-back with latency check
    a_pat = {8{64'h0123_4567_89AB_CDEF}};
    wbuf[0] = a_pat;
    wr_burst(6'd5, 64'h40, 0, '1, -1, 2'b00);
    ar_send(6'd9, 64'h40, 0);
    lat = 1;
    while (!bus.rvalid && lat < 20) begin tick(); lat++; end
    check("ar_to_r_latency", DW'(lat), DW'(2));
    check("single_rdata_const", bus.rdata, a_pat);
    r_collect(6'd9, 1, 1, 1'b0);

    // 16-beat burst, read back with rready toggling
    for (int i = 0; i < 16; i++) wbuf[i] = pat(i);
    wr_burst(6'd1, 64'h0, 15, '1, -1, 2'b00);
    ar_send(6'd2, 64'h0, 15);
    r_collect(6'd2, 0, 16, 1'b1);

    // Byte strobes at index 100
    wbuf[0] = '1;
    wr_burst(6'd3, 64'h1900, 0, '1, -1, 2'b00);
    wbuf[0] = '0;
    wr_burst(6'd3, 64'h1900, 0, 64'h0000_0000_0000_000F, -1, 2'b00);
    ar_send(6'd4, 64'h1900, 0);
    got = 0;
    while (!bus.rvalid && got < 20) begin tick(); got++; end
    exp_v = {{60{8'hFF}}, 32'h0000_0000};
    check("strb_rdata", bus.rdata, exp_v);
    r_collect(6'd4, 100, 1, 1'b0);

    // Wrap-around write at 1022 (upper address bits set) concurrent with a read of 2..9
    for (int i = 0; i < 4; i++) wbuf[i] = pat(200 + i);
    fork
      wr_burst(6'd7, 64'hABCD_0000_0000_FF80, 3, '1, -1, 2'b00);
      begin
        ar_send(6'd8, 64'h80, 7);
        r_collect(6'd8, 2, 8, 1'b0);
      end
    join
    check("wrap_model_idx0", model[0], pat(202));
    ar_send(6'd10, 64'hFF80, 3);
    r_collect(6'd10, 1022, 4, 1'b1);

    // Early wlast on beat 2: all 4 beats accepted, SLVERR
    for (int i = 0; i < 4; i++) wbuf[i] = pat(300 + i);
    wr_burst(6'd11, 64'(300 * 64), 3, '1, 1, 2'b10);
    ar_send(6'd12, 64'(300 * 64), 3);
    r_collect(6'd12, 300, 4, 1'b0);

    // Reset during beat 5 of an 8-beat read
    for (int i = 0; i < 8; i++) wbuf[i] = pat(400 + i);
    wr_burst(6'd13, 64'(400 * 64), 7, '1, -1, 2'b00);
    ar_send(6'd14, 64'(400 * 64), 7);
    got = 0; lat = 0;
    bus.rready = 1'b1;
    while (lat < 100) begin
      if (bus.rvalid && got == 4) break;
      if (bus.rvalid) got++;
      tick();
      lat++;
    end
    check("beat5_reached", DW'(got), DW'(4));
    rst_n = 1'b0;
    #1;
    check("midrst_rvalid", DW'(bus.rvalid), DW'(0));
    check("midrst_rlast", DW'(bus.rlast), DW'(0));
    check("midrst_rdata", bus.rdata, '0);
    bus.rready = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick(); tick();
    check("post_rst_arready", DW'(bus.arready), DW'(1));
    check("post_rst_bvalid", DW'(bus.bvalid), DW'(0));
    ar_send(6'd15, 64'(402 * 64), 1);
    r_collect(6'd15, 402, 2, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=1 want=0");
    $fatal(1, "timeout");
  end
endmodule
